wbu_csr_wr_seq_ysyx_23060136: RTL and testbench

//  Write-back-stage CSR write sequencer; drives the single write port of the CSR file (CSRWr/WBU_csr_rd/csr_busW).

---
 rtl/wbu_csr_wr_seq_ysyx_23060136_if.sv | 28 ++
 rtl/wbu_csr_wr_seq_ysyx_23060136.sv | 124 ++++++++++++
 tb/tb_wbu_csr_wr_seq_ysyx_23060136.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/wbu_csr_wr_seq_ysyx_23060136_if.sv
// Bundle of WBU retire handshake and CSR-file write port signals.
// The sequencer uses the slave view; the WBU/CSR side uses the master view.
interface wbu_csr_wr_seq_ysyx_23060136_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [1:0]      in_csr_rd;
  logic [XLEN-1:0] in_csr_wdata;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] mstatus_cur;
  logic            CSRWr;
  logic [1:0]      WBU_csr_rd;
  logic [XLEN-1:0] csr_busW;
  logic            trap_done;
  logic            busy;

  modport master (
    output in_valid, in_op, in_csr_rd, in_csr_wdata, in_pc, mstatus_cur,
    input  in_ready, CSRWr, WBU_csr_rd, csr_busW, trap_done, busy
  );

  modport slave (
    input  in_valid, in_op, in_csr_rd, in_csr_wdata, in_pc, mstatus_cur,
    output in_ready, CSRWr, WBU_csr_rd, csr_busW, trap_done, busy
  );
endinterface

// File: rtl/wbu_csr_wr_seq_ysyx_23060136.sv
// Write-back CSR write sequencer: one registered write per CSR instruction,
// and an ordered mepc -> mcause (-> mstatus) burst per ecall through the
// single CSR-file write port.
// Optional feature macro: CSR_TRAP_MSTATUS_EN adds the trap mstatus write.
module wbu_csr_wr_seq_ysyx_23060136 #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] MCAUSE_ECALL = XLEN'(32'hb),
  parameter logic [XLEN-1:0] MSTATUS_RST  = XLEN'(32'h1800)
) (
  input logic clk,
  input logic rst,
  wbu_csr_wr_seq_ysyx_23060136_if.slave bus
);

`ifdef CSR_TRAP_MSTATUS_EN
  typedef enum logic [2:0] {S_IDLE, S_SINGLE, S_EPC, S_CAUSE, S_STAT} state_t;
  localparam state_t S_LAST = S_STAT;
`else
  typedef enum logic [2:0] {S_IDLE, S_SINGLE, S_EPC, S_CAUSE} state_t;
  localparam state_t S_LAST = S_CAUSE;
`endif

  state_t          state_q, state_d;
  logic            csr_wr_q, csr_wr_d;
  logic [1:0]      csr_rd_q, csr_rd_d;
  logic [XLEN-1:0] csr_data_q, csr_data_d;
  logic            trap_done_q, trap_done_d;
  logic            busy_q, busy_d;
  logic            in_ready;
  logic            accept;

`ifdef CSR_TRAP_MSTATUS_EN
  // Trap view of mstatus: MPIE takes MIE, MIE cleared, MPP forced to M-mode.
  logic [XLEN-1:0] mstatus_trap;
  assign mstatus_trap = (bus.mstatus_cur & ~XLEN'(32'h1888))
                      | ((bus.mstatus_cur & XLEN'(32'h8)) << 4)
                      | MSTATUS_RST;
`else
  // mstatus is never touched by traps in this build.
  logic unused_mstatus;
  assign unused_mstatus = ^bus.mstatus_cur;
`endif

  // Ready whenever the next cycle is free: idle, single write, or final burst beat.
  assign in_ready = (state_q == S_IDLE) | (state_q == S_SINGLE) | (state_q == S_LAST);
  assign accept   = bus.in_valid & in_ready;

  // Next-state and next-write-port values; write port is zero whenever idle.
  always_comb begin
    state_d     = state_q;
    csr_wr_d    = 1'b0;
    csr_rd_d    = 2'd0;
    csr_data_d  = '0;
    trap_done_d = 1'b0;
    case (state_q)
      S_EPC: begin
        state_d    = S_CAUSE;
        csr_wr_d   = 1'b1;
        csr_rd_d   = 2'd3;
        csr_data_d = MCAUSE_ECALL;
`ifndef CSR_TRAP_MSTATUS_EN
        trap_done_d = 1'b1;
`endif
      end
`ifdef CSR_TRAP_MSTATUS_EN
      S_CAUSE: begin
        state_d     = S_STAT;
        csr_wr_d    = 1'b1;
        csr_rd_d    = 2'd0;
        csr_data_d  = mstatus_trap;
        trap_done_d = 1'b1;
      end
`endif
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          case (bus.in_op)
            2'b01: begin
              state_d    = S_SINGLE;
              csr_wr_d   = 1'b1;
              csr_rd_d   = bus.in_csr_rd;
              csr_data_d = bus.in_csr_wdata;
            end
            2'b10: begin
              state_d    = S_EPC;
              csr_wr_d   = 1'b1;
              csr_rd_d   = 2'd2;
              csr_data_d = bus.in_pc;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_SINGLE);
  end

  // State and registered write-port outputs; reset abandons any burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      csr_wr_q    <= 1'b0;
      csr_rd_q    <= 2'd0;
      csr_data_q  <= '0;
      trap_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      csr_wr_q    <= csr_wr_d;
      csr_rd_q    <= csr_rd_d;
      csr_data_q  <= csr_data_d;
      trap_done_q <= trap_done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.CSRWr      = csr_wr_q;
  assign bus.WBU_csr_rd = csr_rd_q;
  assign bus.csr_busW   = csr_data_q;
  assign bus.trap_done  = trap_done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_wbu_csr_wr_seq_ysyx_23060136.sv
// Bench for the CSR write sequencer: a cycle-indexed schedule of expected
// writes is filled in whenever an instruction is accepted, and compared
// against the write port on every falling edge.
module tb_wbu_csr_wr_seq_ysyx_23060136;
  localparam int XLEN = 32;
`ifdef CSR_TRAP_MSTATUS_EN
  localparam int BURST = 3;
`else
  localparam int BURST = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   check_en = 1'b0;
  bit   acc;

  // Expected behaviour keyed by cycle number.
  bit          exp_wr[int];
  logic [1:0]  exp_rd[int];
  logic [31:0] exp_data[int];
  bit          exp_td[int];
  bit          exp_nrdy[int];
  bit          exp_busy[int];

  wbu_csr_wr_seq_ysyx_23060136_if #(.XLEN(XLEN)) bus ();

  wbu_csr_wr_seq_ysyx_23060136 #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One comparison: counts, and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Place one expected write into the schedule.
  function automatic void schedWrite(input int c, input logic [1:0] rd, input logic [31:0] d, input bit td);
    exp_wr[c]   = 1'b1;
    exp_rd[c]   = rd;
    exp_data[c] = d;
    exp_td[c]   = td;
  endfunction

`ifdef CSR_TRAP_MSTATUS_EN
  // Trap mstatus: MPIE <- MIE, MIE <- 0, MPP <- M.
  function automatic logic [31:0] trapStatus(input logic [31:0] m);
    logic [31:0] r;
    r        = m;
    r[7]     = m[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction
`endif

  // Drive one cycle of WBU input; the model decides acceptance from its own ready.
  task automatic applyStimulus(input bit v, input logic [1:0] op, input logic [1:0] rd,
                               input logic [31:0] wd, input logic [31:0] pc,
                               input logic [31:0] ms, output bit accepted);
    bus.in_valid     = v;
    bus.in_op        = op;
    bus.in_csr_rd    = rd;
    bus.in_csr_wdata = wd;
    bus.in_pc        = pc;
    bus.mstatus_cur  = ms;
    accepted = v && !exp_nrdy.exists(cyc);
    if (accepted && op == 2'b01) schedWrite(cyc + 1, rd, wd, 1'b0);
    if (accepted && op == 2'b10) begin
      schedWrite(cyc + 1, 2'd2, pc, 1'b0);
`ifdef CSR_TRAP_MSTATUS_EN
      schedWrite(cyc + 2, 2'd3, 32'hb, 1'b0);
      schedWrite(cyc + 3, 2'd0, trapStatus(ms), 1'b1);
`else
      schedWrite(cyc + 2, 2'd3, 32'hb, 1'b1);
`endif
      for (int k = 1; k < BURST; k++) exp_nrdy[cyc + k] = 1'b1;
      for (int k = 1; k <= BURST; k++) exp_busy[cyc + k] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 2'd0, 32'h0, 32'h0, 32'h0, acc);
  endtask

  // Every-cycle compare of the write port against the schedule.
  always @(negedge clk) begin
    if (check_en) begin
      if (rst) begin
        checkOutput("rst_CSRWr", {31'd0, bus.CSRWr}, 32'd0);
        checkOutput("rst_busW", bus.csr_busW, 32'd0);
        checkOutput("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
      end else begin
        checkOutput("CSRWr", {31'd0, bus.CSRWr}, {31'd0, exp_wr.exists(cyc)});
        checkOutput("WBU_csr_rd", {30'd0, bus.WBU_csr_rd}, exp_wr.exists(cyc) ? {30'd0, exp_rd[cyc]} : 32'd0);
        checkOutput("csr_busW", bus.csr_busW, exp_wr.exists(cyc) ? exp_data[cyc] : 32'd0);
        checkOutput("trap_done", {31'd0, bus.trap_done}, exp_wr.exists(cyc) ? {31'd0, exp_td[cyc]} : 32'd0);
        checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, !exp_nrdy.exists(cyc)});
        checkOutput("busy", {31'd0, bus.busy}, {31'd0, exp_busy.exists(cyc)});
      end
    end
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios with hand-computed literal pins.
  initial begin
    bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_csr_rd = 2'd0;
    bus.in_csr_wdata = '0; bus.in_pc = '0; bus.mstatus_cur = '0;
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_CSRWr", {31'd0, bus.CSRWr}, 32'd0);
    checkOutput("reset_rd", {30'd0, bus.WBU_csr_rd}, 32'd0);
    checkOutput("reset_busW", bus.csr_busW, 32'd0);
    checkOutput("reset_trap_done", {31'd0, bus.trap_done}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_ready", {31'd0, bus.in_ready}, 32'd1);
    check_en = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // T1: single write, one cycle later, then quiet.
    applyStimulus(1'b1, 2'b01, 2'd1, 32'h80000100, 32'h0, 32'h0, acc);
    checkOutput("T1_CSRWr", {31'd0, bus.CSRWr}, 32'd1);
    checkOutput("T1_rd", {30'd0, bus.WBU_csr_rd}, 32'd1);
    checkOutput("T1_busW", bus.csr_busW, 32'h80000100);
    idle(1);
    checkOutput("T1_CSRWr_off", {31'd0, bus.CSRWr}, 32'd0);

    // T2: four back-to-back writes.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 2'b01, 2'(i), 32'h1000 + 32'(i) * 32'h11, 32'h0, 32'h0, acc);
    checkOutput("T2_last_rd", {30'd0, bus.WBU_csr_rd}, 32'd3);
    checkOutput("T2_last_busW", bus.csr_busW, 32'h1033);
    idle(2);

    // T3: ecall burst, with a CSR write held while ready is low.
    applyStimulus(1'b1, 2'b10, 2'd0, 32'h0, 32'h80000010, 32'h0, acc);
    checkOutput("T3_epc_rd", {30'd0, bus.WBU_csr_rd}, 32'd2);
    checkOutput("T3_epc_busW", bus.csr_busW, 32'h80000010);
    checkOutput("T3_ready_low", {31'd0, bus.in_ready}, 32'd0);
    acc = 1'b0;
    for (int t = 0; t < 6 && !acc; t++) begin
      applyStimulus(1'b1, 2'b01, 2'd1, 32'h0000cafe, 32'h0, 32'h0, acc);
      if (t == 0) begin
        checkOutput("T3_cause_rd", {30'd0, bus.WBU_csr_rd}, 32'd3);
        checkOutput("T3_cause_busW", bus.csr_busW, 32'hb);
`ifdef CSR_TRAP_MSTATUS_EN
        checkOutput("T3_cause_td", {31'd0, bus.trap_done}, 32'd0);
`else
        checkOutput("T3_cause_td", {31'd0, bus.trap_done}, 32'd1);
`endif
      end
    end
    if (!acc) checkOutput("T3_held_accept", 32'd0, 32'd1);
    idle(2);

    // T4: ecall with mstatus_cur = 0x1808; third write only in the trap-mstatus build.
    applyStimulus(1'b1, 2'b10, 2'd0, 32'h0, 32'h80000200, 32'h1808, acc);
    bus.in_valid = 1'b0;
    idle(2);
`ifdef CSR_TRAP_MSTATUS_EN
    checkOutput("T4_stat_CSRWr", {31'd0, bus.CSRWr}, 32'd1);
    checkOutput("T4_stat_rd", {30'd0, bus.WBU_csr_rd}, 32'd0);
    checkOutput("T4_stat_busW", bus.csr_busW, 32'h1880);
    checkOutput("T4_stat_td", {31'd0, bus.trap_done}, 32'd1);
`else
    checkOutput("T4_no_stat_CSRWr", {31'd0, bus.CSRWr}, 32'd0);
`endif
    idle(2);

    // T5: reset during the mepc beat abandons the rest of the burst.
    applyStimulus(1'b1, 2'b10, 2'd0, 32'h0, 32'h80000300, 32'h8, acc);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    exp_wr.delete(); exp_rd.delete(); exp_data.delete();
    exp_td.delete(); exp_nrdy.delete(); exp_busy.delete();
    #1;
    checkOutput("T5_CSRWr_now", {31'd0, bus.CSRWr}, 32'd0);
    checkOutput("T5_busy_now", {31'd0, bus.busy}, 32'd0);
    checkOutput("T5_ready_now", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    idle(4);

    // T6: op 11 and op 00 are accepted silently, then a normal write.
    applyStimulus(1'b1, 2'b11, 2'd2, 32'hdeadbeef, 32'h0, 32'h0, acc);
    checkOutput("T6_op11_CSRWr", {31'd0, bus.CSRWr}, 32'd0);
    applyStimulus(1'b1, 2'b00, 2'd2, 32'hdeadbeef, 32'h0, 32'h0, acc);
    checkOutput("T6_op00_ready", {31'd0, bus.in_ready}, 32'd1);
    applyStimulus(1'b1, 2'b01, 2'd3, 32'h00005a5a, 32'h0, 32'h0, acc);
    checkOutput("T6_write_busW", bus.csr_busW, 32'h00005a5a);
    idle(3);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
